// File: rtl/seq_detect_param.sv
// Runtime-configurable serial bit-pattern detector with registered match flag,
// overlap/non-overlap modes and a saturating match counter.
module seq_detect_param #(
  parameter int unsigned        MAX_LEN     = 8,
  parameter int unsigned        LEN_W       = 4,
  parameter int unsigned        CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0000_1011,
  parameter logic [LEN_W-1:0]   DEF_LEN     = 4'd4,
  parameter logic               DEF_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               count_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic [LEN_W-1:0]   cur_len
);

  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_match;
  logic [CNT_W-1:0]   r_count;

  logic [MAX_LEN-1:0] w_pattern_n;
  logic [LEN_W-1:0]   w_len_n;
  logic               w_overlap_n;
  logic [MAX_LEN-1:0] w_hist_n;
  logic [LEN_W-1:0]   w_fill_n;
  logic               w_match_n;
  logic [CNT_W-1:0]   w_count_n;

  logic [MAX_LEN-1:0] w_mask;
  logic [MAX_LEN-1:0] w_hist_sh;
  logic [LEN_W-1:0]   w_fill_inc;
  logic               w_cmp;
  logic               w_accept;
  logic               w_hit;

  always_comb begin
    // Only the low len bits of history/pattern take part in the compare.
    w_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < 32'(r_len));
    end

    w_hist_sh  = {r_hist[MAX_LEN-2:0], din};
    w_fill_inc = (r_fill >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : r_fill + LEN_W'(1);
    w_cmp      = (((w_hist_sh ^ r_pattern) & w_mask) == '0);
    w_accept   = din_valid & ~cfg_load;
    w_hit      = w_accept && (r_len != '0) && (w_fill_inc >= r_len) && w_cmp;

    w_pattern_n = r_pattern;
    w_len_n     = r_len;
    w_overlap_n = r_overlap;
    w_hist_n    = r_hist;
    w_fill_n    = r_fill;
    w_match_n   = 1'b0;

    if (cfg_load) begin
      w_pattern_n = cfg_pattern;
      w_len_n     = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
      w_overlap_n = cfg_overlap;
      w_hist_n    = '0;
      w_fill_n    = '0;
    end else if (din_valid) begin
      w_hist_n  = w_hist_sh;
      // Non-overlap restarts the fill count so the next hit needs len fresh bits.
      w_fill_n  = (w_hit && !r_overlap) ? '0 : w_fill_inc;
      w_match_n = w_hit;
    end

    w_count_n = r_count;
    if (count_clr) begin
      w_count_n = '0;
    end else if (w_hit && (r_count != '1)) begin
      w_count_n = r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pattern <= DEF_PATTERN;
      r_len     <= DEF_LEN;
      r_overlap <= DEF_OVERLAP;
      r_hist    <= '0;
      r_fill    <= '0;
      r_match   <= 1'b0;
      r_count   <= '0;
    end else begin
      r_pattern <= w_pattern_n;
      r_len     <= w_len_n;
      r_overlap <= w_overlap_n;
      r_hist    <= w_hist_n;
      r_fill    <= w_fill_n;
      r_match   <= w_match_n;
      r_count   <= w_count_n;
    end
  end

  assign match       = r_match;
  assign match_count = r_count;
  assign cur_len     = r_len;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: directed scenarios plus random traffic
// checked against a queue-based reference model of the detector rules.
module tb_seq_detect_param;

  logic       clk;
  logic       rst;
  logic       din_valid;
  logic       din;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       count_clr;
  logic       match;
  logic [3:0] match_count;
  logic [3:0] cur_len;

  seq_detect_param #(
    .MAX_LEN    (8),
    .LEN_W      (4),
    .CNT_W      (4),
    .DEF_PATTERN(8'b0000_1011),
    .DEF_LEN    (4'd4),
    .DEF_OVERLAP(1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din        (din),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .count_clr  (count_clr),
    .match      (match),
    .match_count(match_count),
    .cur_len    (cur_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       m;
    logic [3:0] c;
    logic [3:0] l;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Reference model: received bits kept as a list, pattern read first-bit-first.
  bit         mq[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         m_cnt;
  bit         m_match;

  task automatic model_reset();
    m_pat   = 8'h0B;
    m_len   = 4;
    m_ovl   = 1'b1;
    mq.delete();
    m_cnt   = 0;
    m_match = 1'b0;
  endtask

  task automatic model_step(input bit r, v, d, ld, input logic [7:0] p,
                            input logic [3:0] l, input bit o, c);
    bit hit;
    int n;
    hit = 1'b0;
    if (r) begin
      model_reset();
    end else begin
      if (ld) begin
        m_pat = p;
        m_len = (int'(l) > 8) ? 8 : int'(l);
        m_ovl = o;
        mq.delete();
      end else if (v) begin
        mq.push_back(d);
        if (mq.size() > 8) void'(mq.pop_front());
        n = mq.size();
        if (m_len > 0 && n >= m_len) begin
          hit = 1'b1;
          for (int k = 0; k < m_len; k++)
            if (mq[n - m_len + k] != m_pat[m_len - 1 - k]) hit = 1'b0;
        end
        if (hit && !m_ovl) mq.delete();
      end
      m_match = hit;
      if (c) m_cnt = 0;
      else if (hit && m_cnt < 15) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic step(input bit r, v, d, ld, input logic [7:0] p,
                      input logic [3:0] l, input bit o, c);
    exp_t e;
    @(negedge clk);
    rst = r; din_valid = v; din = d; cfg_load = ld;
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; count_clr = c;
    @(posedge clk);
    model_step(r, v, d, ld, p, l, o, c);
    e.m = m_match;
    e.c = 4'(m_cnt);
    e.l = 4'(m_len);
    exp_q.push_back(e);
  endtask

  task automatic feed(input bit d);
    step(1'b0, 1'b1, d, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o);
    step(1'b0, 1'b0, 1'b0, 1'b1, p, l, o, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic feed_bits(input logic [15:0] bits, input int n);
    logic [15:0] b;
    b = bits;
    for (int i = n - 1; i >= 0; i--) feed(b[i]);
  endtask

  // Monitor: outputs are registered, so every cycle presents a response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cycle++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (match !== e.m) begin
          errors++;
          $display("FAIL match @%0d: got %0b expected %0b", cycle, match, e.m);
        end
        checks++;
        if (match_count !== e.c) begin
          errors++;
          $display("FAIL match_count @%0d: got %0d expected %0d", cycle, match_count, e.c);
        end
        checks++;
        if (cur_len !== e.l) begin
          errors++;
          $display("FAIL cur_len @%0d: got %0d expected %0d", cycle, cur_len, e.l);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; din_valid = 1'b0; din = 1'b0; cfg_load = 1'b0;
    cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0; count_clr = 1'b0;
    model_reset();

    do_reset();
    idle();
    // Default overlap detector on 1011011
    feed_bits(16'b1011011, 7);
    idle();

    // Non-overlap, same stream then a fresh 1011
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    load(8'h0B, 4'd4, 1'b0);
    feed_bits(16'b1011011, 7);
    feed_bits(16'b1011, 4);
    idle();

    // Gapped valid
    load(8'h0B, 4'd4, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      feed(i != 2);
      repeat (3) idle();
    end

    // Clamping and disabled length
    load(8'hFF, 4'd12, 1'b1);
    feed_bits(16'hFFFF, 10);
    load(8'h00, 4'd0, 1'b1);
    for (int i = 0; i < 12; i++) feed(1'($urandom_range(0, 1)));
    feed_bits(16'h0000, 6);

    // Length 1
    load(8'h01, 4'd1, 1'b1);
    feed_bits(16'b1101, 4);
    idle();

    // Saturation then clear coincident with a hit
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) feed(1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    idle();

    // Mid-sequence abort by reset, then by cfg_load with a coincident bit
    load(8'h0B, 4'd4, 1'b1);
    feed_bits(16'b101, 3);
    do_reset();
    feed(1'b1);
    idle();
    feed_bits(16'b101, 3);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h0B, 4'd4, 1'b1, 1'b0);
    feed(1'b1);
    feed_bits(16'b011, 3);
    idle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, v, d, ld, o, c;
      logic [7:0] p;
      logic [3:0] l;
      r  = ($urandom_range(0, 199) == 0);
      v  = ($urandom_range(0, 9) < 7);
      d  = 1'($urandom_range(0, 1));
      ld = ($urandom_range(0, 39) == 0);
      p  = 8'($urandom_range(0, 255));
      l  = 4'($urandom_range(0, 4) == 0 ? $urandom_range(0, 15) : $urandom_range(1, 3));
      o  = 1'($urandom_range(0, 1));
      c  = ($urandom_range(0, 59) == 0);
      step(r, v, d, ld, p, l, o, c);
    end

    repeat (3) idle();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
